// File: rtl/split_radio_pkg.sv
// Shared line-coding definitions for the radio/wire link; the receive splitter
// decodes the same symbols and tags that the merge transmitter drives.
package split_radio_pkg;

  // Differential symbols as {plus, minus}; 2'b11 is never a legal line state.
  localparam logic [1:0] SYM_ONE  = 2'b10;
  localparam logic [1:0] SYM_ZERO = 2'b01;
  localparam logic [1:0] SYM_IDLE = 2'b00;

  localparam logic TAG_RADIO = 1'b1;
  localparam logic TAG_WIRE  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_TAG    = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_GAP    = 3'd5
  } tx_state_t;

  function automatic logic [1:0] sym_of_bit(input logic b);
    return b ? SYM_ONE : SYM_ZERO;
  endfunction

endpackage

// File: rtl/differential_line_pipe.sv
// Fixed-depth register pipeline between the serializer and the line pins,
// reset to IDLE, with a flag telling whether any stage still holds a live symbol.
module differential_line_pipe
  import split_radio_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sym,
  output logic [1:0] line,
  output logic       active
);

  logic [1:0] stage_r [STAGES];

  // Symbol shift register, one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_r[i] <= SYM_IDLE;
    end else begin
      stage_r[0] <= sym;
      for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  // Any stage carrying a non-idle symbol keeps the transmitter busy.
  always_comb begin
    active = 1'b0;
    for (int i = 0; i < STAGES; i++) active = active | (stage_r[i] != SYM_IDLE);
  end

  assign line = stage_r[STAGES-1];

endmodule

// File: rtl/merge_radio_transmit.sv
// Merges radio and wire words onto one differential pair: round-robin arbiter,
// framing FSM (START, TAG, data MSB first, even parity, gap) and output pipeline.
module merge_radio_transmit
  import split_radio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             Clock,
  input  logic             Reset_N,
  input  logic [WIDTH-1:0] Radio_Data,
  input  logic             Radio_Valid,
  output logic             Radio_Ready,
  input  logic [WIDTH-1:0] Wire_Data,
  input  logic             Wire_Valid,
  output logic             Wire_Ready,
  output logic             Transmit_Plus,
  output logic             Transmit_Minus,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
  // The IDLE cycle itself supplies the last gap symbol, so GAP lasts GAP_CYCLES-1
  // cycles; with no gap at all, the parity cycle doubles as the arbitration slot.
  localparam bit NO_GAP        = (GAP_CYCLES == 32'sd0);
  localparam bit HAS_GAP_STATE = (GAP_CYCLES > 32'sd1);

  tx_state_t        state_r, state_s;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic [GW-1:0]    gap_cnt_r;
  logic             tag_r, par_r, last_tag_r, ready_en_r;
  logic             accept_s, radio_xfer_s, wire_xfer_s, xfer_s, pipe_active_s;
  logic [1:0]       sym_s, line_s;

  // ready_en_r holds both Ready lines low until the first edge after reset release.
  assign accept_s     = ready_en_r && ((state_r == ST_IDLE) || (NO_GAP && (state_r == ST_PARITY)));
  assign Radio_Ready  = accept_s && (!Wire_Valid || (last_tag_r == TAG_WIRE));
  assign Wire_Ready   = accept_s && (!Radio_Valid || (last_tag_r == TAG_RADIO));
  assign radio_xfer_s = Radio_Valid && Radio_Ready;
  assign wire_xfer_s  = Wire_Valid && Wire_Ready;
  assign xfer_s       = radio_xfer_s || wire_xfer_s;

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Next-state and serializer symbol selection.
  always_comb begin
    state_s = state_r;
    sym_s   = SYM_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) state_s = ST_START;
        else        state_s = ST_IDLE;
      end
      ST_START: begin
        sym_s   = SYM_ONE;
        state_s = ST_TAG;
      end
      ST_TAG: begin
        sym_s   = sym_of_bit(tag_r);
        state_s = ST_DATA;
      end
      ST_DATA: begin
        sym_s = sym_of_bit(shift_r[WIDTH-1]);
        if (cnt_r == {CW{1'b0}}) state_s = ST_PARITY;
        else                     state_s = ST_DATA;
      end
      ST_PARITY: begin
        sym_s = sym_of_bit(par_r);
        if (xfer_s)             state_s = ST_START;
        else if (HAS_GAP_STATE) state_s = ST_GAP;
        else                    state_s = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_r == {GW{1'b0}}) state_s = ST_IDLE;
        else                         state_s = ST_GAP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Word capture, bit shifting, parity accumulation and gap counting.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      shift_r    <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      gap_cnt_r  <= {GW{1'b0}};
      tag_r      <= TAG_WIRE;
      par_r      <= 1'b0;
      last_tag_r <= TAG_WIRE;
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (xfer_s) begin
        shift_r    <= radio_xfer_s ? Radio_Data : Wire_Data;
        tag_r      <= radio_xfer_s ? TAG_RADIO : TAG_WIRE;
        par_r      <= radio_xfer_s ? TAG_RADIO : TAG_WIRE;
        last_tag_r <= radio_xfer_s ? TAG_RADIO : TAG_WIRE;
        cnt_r      <= CW'(WIDTH - 1);
      end else if (state_r == ST_DATA) begin
        shift_r <= {shift_r[WIDTH-2:0], 1'b0};
        par_r   <= par_r ^ shift_r[WIDTH-1];
        cnt_r   <= cnt_r - CW'(32'd1);
      end else if (state_r == ST_PARITY) begin
        gap_cnt_r <= GW'(GAP_CYCLES - 2);
      end else if (state_r == ST_GAP) begin
        gap_cnt_r <= gap_cnt_r - GW'(32'd1);
      end
    end
  end

  differential_line_pipe #(.STAGES(PIPE_STAGES)) u_line_pipe (
    .clk    (Clock),
    .rst_n  (Reset_N),
    .sym    (sym_s),
    .line   (line_s),
    .active (pipe_active_s)
  );

  assign Transmit_Plus  = line_s[1];
  assign Transmit_Minus = line_s[0];
  assign Busy           = (state_r != ST_IDLE) || pipe_active_s;

endmodule

// File: tb/tb_merge_radio_transmit.sv
// Scoreboard bench: drivers push expected frames on each handshake, monitors
// decode the differential pins and compare against the queues.
module tb_merge_radio_transmit;

  logic       Clock = 1'b0;
  logic       Reset_N;
  logic [7:0] Radio_Data, Wire_Data;
  logic       Radio_Valid, Wire_Valid;
  logic       Radio_Ready, Wire_Ready, Transmit_Plus, Transmit_Minus, Busy;
  logic [3:0] r4_data, w4_data;
  logic       r4_valid, w4_valid, r4_ready, w4_ready, p4, m4, busy4;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct { bit tag; logic [7:0] data; bit par; int gap; int xcyc; } exp_t;
  typedef struct { int c; logic [1:0] s; } sx_t;
  exp_t exp_q[$];
  sx_t  s4_q[$];

  merge_radio_transmit dut (
    .Clock(Clock), .Reset_N(Reset_N),
    .Radio_Data(Radio_Data), .Radio_Valid(Radio_Valid), .Radio_Ready(Radio_Ready),
    .Wire_Data(Wire_Data), .Wire_Valid(Wire_Valid), .Wire_Ready(Wire_Ready),
    .Transmit_Plus(Transmit_Plus), .Transmit_Minus(Transmit_Minus), .Busy(Busy)
  );

  merge_radio_transmit #(.WIDTH(4), .PIPE_STAGES(1), .GAP_CYCLES(0)) dut4 (
    .Clock(Clock), .Reset_N(Reset_N),
    .Radio_Data(r4_data), .Radio_Valid(r4_valid), .Radio_Ready(r4_ready),
    .Wire_Data(w4_data), .Wire_Valid(w4_valid), .Wire_Ready(w4_ready),
    .Transmit_Plus(p4), .Transmit_Minus(m4), .Busy(busy4)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame decoder for the default instance.
  always @(negedge Clock) begin : mon
    logic [1:0] sym;
    logic [9:0] bits;
    bit         in_frame;
    int         nsym, idle_run, start_cyc, gap_seen;
    exp_t       e;
    sym = {Transmit_Plus, Transmit_Minus};
    if (!Reset_N) begin
      in_frame = 1'b0;
      idle_run = 0;
    end else begin
      check("no_11_on_pins", int'(sym == 2'b11), 0);
      if (!in_frame) begin
        if (sym == 2'b10) begin
          in_frame = 1'b1; nsym = 1; bits = 10'd0; start_cyc = cyc; gap_seen = idle_run;
        end else begin
          check("idle_outside_frame", int'(sym), 0);
          idle_run++;
        end
      end else begin
        check("no_idle_in_frame", int'(sym == 2'b00), 0);
        bits = {bits[8:0], sym == 2'b10};
        nsym++;
        if (nsym == 11) begin
          in_frame = 1'b0;
          idle_run = 0;
          if (exp_q.size() == 0) check("unexpected_frame", 0, 1);
          else begin
            e = exp_q.pop_front();
            check("frame_tag", int'(bits[9]), int'(e.tag));
            check("frame_data", int'(bits[8:1]), int'(e.data));
            check("frame_parity", int'(bits[0]), int'(e.par));
            check("start_latency", start_cyc - e.xcyc, 3);
            if (e.gap >= 0) check("idle_gap", gap_seen, e.gap);
          end
        end
      end
    end
  end

  // Symbol-by-symbol checker for the narrow instance.
  always @(negedge Clock) begin
    if (Reset_N) begin
      check("w4_no_11", int'(p4 && m4), 0);
      if (s4_q.size() > 0) begin
        if (s4_q[0].c == cyc) begin
          check("w4_symbol", int'({p4, m4}), int'(s4_q[0].s));
          void'(s4_q.pop_front());
        end else if (s4_q[0].c < cyc) begin
          check("w4_missed_symbol", cyc, s4_q[0].c);
          void'(s4_q.pop_front());
        end
      end
    end
  end

  task automatic send(input bit radio, input logic [7:0] d, input bit par, input int gap,
                      input bit hold, output int xc);
    int  n;
    bit  done;
    n = 0; done = 1'b0; xc = -1;
    @(negedge Clock);
    if (radio) begin Radio_Valid = 1'b1; Radio_Data = d; end
    else       begin Wire_Valid  = 1'b1; Wire_Data  = d; end
    while (!done && n < 300) begin
      #1;
      if ((radio && Radio_Ready) || (!radio && Wire_Ready)) begin
        @(posedge Clock);
        #1;
        xc = cyc;
        exp_q.push_back('{tag: radio, data: d, par: par, gap: gap, xcyc: cyc});
        done = 1'b1;
        if (!hold) begin
          if (radio) Radio_Valid = 1'b0;
          else       Wire_Valid  = 1'b0;
        end
      end else begin
        @(negedge Clock);
        n++;
      end
    end
    if (!done) check(radio ? "radio_handshake_timeout" : "wire_handshake_timeout", 0, 1);
  endtask

  task automatic at_cyc(input int c);
    do @(negedge Clock); while (cyc < c);
    #1;
  endtask

  initial begin
    int e, xr, xw, first, n;
    Reset_N = 1'b0;
    Radio_Valid = 1'b0; Wire_Valid = 1'b0; Radio_Data = 8'h00; Wire_Data = 8'h00;
    r4_valid = 1'b0; w4_valid = 1'b0; r4_data = 4'h0; w4_data = 4'h0;
    repeat (2) @(negedge Clock);
    Radio_Valid = 1'b1; Wire_Valid = 1'b1;
    #1;
    check("reset_pins", int'({Transmit_Plus, Transmit_Minus}), 0);
    check("reset_busy", int'(Busy), 0);
    check("reset_ready", int'({Radio_Ready, Wire_Ready}), 0);
    @(negedge Clock);
    Radio_Valid = 1'b0; Wire_Valid = 1'b0;
    Reset_N = 1'b1;

    // Single radio word A5: parity = tag 1 ^ four ones = 1.
    send(1'b1, 8'hA5, 1'b1, -1, 1'b0, e);
    at_cyc(e + 13);
    check("busy_last_parity", int'(Busy), 1);
    at_cyc(e + 14);
    check("busy_dropped", int'(Busy), 0);

    // Single wire word 00; Ready must return only in the IDLE cycle E+11.
    send(1'b0, 8'h00, 1'b0, -1, 1'b0, e);
    first = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      #1;
      if (Wire_Ready && first < 0) first = cyc;
    end
    check("wire_ready_return", first - e, 11);

    // Both sources held: strict alternation starting with radio, one IDLE between frames.
    fork
      begin
        send(1'b1, 8'h12, 1'b1, -1, 1'b1, xr);
        send(1'b1, 8'h34, 1'b0,  1, 1'b1, xr);
        send(1'b1, 8'h56, 1'b1,  1, 1'b1, xr);
        send(1'b1, 8'h78, 1'b1,  1, 1'b0, xr);
      end
      begin
        send(1'b0, 8'h9A, 1'b0, 1, 1'b1, xw);
        send(1'b0, 8'hBC, 1'b1, 1, 1'b1, xw);
        send(1'b0, 8'hDE, 1'b0, 1, 1'b1, xw);
        send(1'b0, 8'hF0, 1'b0, 1, 1'b0, xw);
      end
    join

    // Inputs wiggled mid-frame: no Ready, frame keeps the captured 3C.
    send(1'b1, 8'h3C, 1'b1, -1, 1'b0, e);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      Radio_Data = 8'h5A ^ 8'(k);
      Wire_Data = 8'(k);
      Radio_Valid = k[0];
      Wire_Valid = k[1];
      #1;
      check("no_ready_mid_frame", int'(Radio_Ready | Wire_Ready), 0);
    end
    @(negedge Clock);
    Radio_Valid = 1'b0; Wire_Valid = 1'b0;
    repeat (20) @(negedge Clock);

    // Reset mid-frame after a radio grant, then a tie must go to radio first.
    send(1'b1, 8'hFF, 1'b1, -1, 1'b0, e);
    repeat (5) @(negedge Clock);
    Reset_N = 1'b0;
    Radio_Valid = 1'b1;
    #1;
    check("midframe_reset_pins", int'({Transmit_Plus, Transmit_Minus}), 0);
    check("midframe_reset_busy", int'(Busy), 0);
    check("midframe_reset_ready", int'(Radio_Ready), 0);
    exp_q.delete();
    Radio_Valid = 1'b0;
    repeat (2) @(negedge Clock);
    Reset_N = 1'b1;
    fork
      send(1'b1, 8'h81, 1'b1, -1, 1'b0, xr);
      send(1'b0, 8'h7E, 1'b0,  1, 1'b0, xw);
    join
    check("tie_after_reset_radio_first", int'(xr < xw), 1);

    // Narrow instance: 4'hF radio then wire 0 right after its parity symbol.
    @(negedge Clock);
    r4_valid = 1'b1; r4_data = 4'hF;
    n = 0;
    #1;
    while (!r4_ready && n < 50) begin @(negedge Clock); #1; n++; end
    check("w4_radio_handshake", int'(r4_ready), 1);
    @(posedge Clock);
    #1;
    e = cyc;
    for (int c = 1; c <= 8; c++) s4_q.push_back('{c: e + c, s: 2'b10});
    for (int c = 9; c <= 14; c++) s4_q.push_back('{c: e + c, s: 2'b01});
    s4_q.push_back('{c: e + 15, s: 2'b00});
    @(negedge Clock);
    r4_valid = 1'b0; w4_valid = 1'b1; w4_data = 4'h0;
    n = 0;
    #1;
    while (!w4_ready && n < 50) begin @(negedge Clock); #1; n++; end
    @(posedge Clock);
    #1;
    check("w4_next_transfer_edge", cyc - e, 7);
    w4_valid = 1'b0;

    n = 0;
    while ((s4_q.size() != 0 || exp_q.size() != 0) && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check("scoreboard_drained", s4_q.size() + exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
